// File: rtl/irda_mir_pkg.sv
// Shared types and constants for the MIR receive path.
package irda_mir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HUNT = 2'd1,
      ST_FLAG = 2'd2,
      ST_DATA = 2'd3
   } mir_state_e;

   localparam logic [7:0]  MIR_FLAG           = 8'h7E;
   localparam int unsigned MIR_STUFF_ONES     = 5;
   localparam int unsigned MIR_FLAG_TAIL_BITS = 6;

   localparam int unsigned ONES_W   = 3;
   localparam int unsigned BITCNT_W = 3;

   // One-clk event strobes produced by the frame controller.
   typedef struct packed {
      logic sof;
      logic dv;
      logic eof;
      logic err;
      logic abort;
   } mir_evt_t;

   // Saturating increment of the raw ones run length.
   function automatic logic [ONES_W-1:0] ones_sat_inc(input logic [ONES_W-1:0] ones);
      return (ones == '1) ? ones : ones + ONES_W'(1);
   endfunction

endpackage

// File: rtl/irda_mir_rx_destuff.sv
// MIR raw-bit front end: flag detection, zero destuffing and LSB-first byte assembly.
// The raw window is the incoming bit plus the 7 stored history bits.
module irda_mir_rx_destuff
   import irda_mir_pkg::*;
(
   input  logic                clk,
   input  logic                wb_rst_i,
   input  logic                bit_en,
   input  logic                rx,
   output logic                flag_det_c,
   output logic                byte_done_c,
   output logic [7:0]          byte_c,
   output logic [BITCNT_W-1:0] bitcnt
);

   logic [6:0]          raw_q;
   logic [7:0]          raw_shift;
   logic [6:0]          byte_q;
   logic [7:0]          byte_shift;
   logic [ONES_W-1:0]   ones_q;
   logic [BITCNT_W-1:0] bitcnt_q;
   logic                drop;
   logic                skip;
   logic                append;

   assign raw_shift  = {rx, raw_q};
   assign byte_shift = {rx, byte_q};

   // A flag always wins over stuffing decisions for the same bit.
   assign flag_det_c  = bit_en & (raw_shift == MIR_FLAG);
   assign drop        = ~rx & (ones_q == ONES_W'(MIR_STUFF_ONES));
   assign skip        =  rx & (ones_q >= ONES_W'(MIR_STUFF_ONES));
   assign append      = bit_en & ~flag_det_c & ~drop & ~skip;
   assign byte_done_c = append & (bitcnt_q == '1);
   assign byte_c      = byte_shift;
   assign bitcnt      = bitcnt_q;

   // Raw history, ones run length and byte assembly, advanced once per valid bit.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         raw_q    <= '0;
         byte_q   <= '0;
         ones_q   <= '0;
         bitcnt_q <= '0;
      end else if (bit_en) begin
         if (flag_det_c) begin
            raw_q    <= '0;
            ones_q   <= '0;
            bitcnt_q <= '0;
         end else begin
            raw_q  <= raw_shift[7:1];
            ones_q <= rx ? ones_sat_inc(ones_q) : '0;
            if (append) begin
               byte_q   <= byte_shift[7:1];
               bitcnt_q <= bitcnt_q + BITCNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/irda_mir_rx_ctrl.sv
// MIR receive-frame controller: flag hunt, frame sequencing, length check and event strobes.
// Optional statistics counters are built when IRDA_MIR_RX_STATS_EN is defined.
module irda_mir_rx_ctrl
   import irda_mir_pkg::*;
#(
   parameter int unsigned MAX_LEN = 2048,
   parameter int unsigned LEN_W   = 12,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             wb_rst_i,
   input  logic             mir_rxbit_enable,
   input  logic             rx_i,
   input  logic             brd_i,
   input  logic             rx_en_i,
   output logic [7:0]       data_o,
   output logic             data_valid_o,
   output logic             sof_o,
   output logic             eof_o,
   output logic             err_o,
   output logic             abort_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic [CNT_W-1:0] abort_cnt_o
);

   mir_state_e          state_q;
   mir_state_e          state_nxt;
   mir_evt_t            evt_nxt;
   logic                load_data;
   logic                brd_q;
   logic                brk_rise;
   logic                flag_det_c;
   logic                byte_done_c;
   logic [7:0]          byte_c;
   logic [BITCNT_W-1:0] bitcnt;
   logic [LEN_W-1:0]    byte_cnt_q;
   logic                over_len;
   logic                tail_ok;

   irda_mir_rx_destuff u_destuff (
      .clk         (clk),
      .wb_rst_i    (wb_rst_i),
      .bit_en      (mir_rxbit_enable),
      .rx          (rx_i),
      .flag_det_c  (flag_det_c),
      .byte_done_c (byte_done_c),
      .byte_c      (byte_c),
      .bitcnt      (bitcnt)
   );

   assign brk_rise = brd_i & ~brd_q;
   assign over_len = (byte_cnt_q == LEN_W'(MAX_LEN));
   // An aligned closing flag leaves exactly its leading zero plus five ones in the assembler.
   assign tail_ok  = (bitcnt == BITCNT_W'(MIR_FLAG_TAIL_BITS));

   // State register and break edge detector.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         brd_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         brd_q   <= brd_i;
      end
   end

   // Next-state: disable overrides everything, then break, flag, overlength, byte.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: if (rx_en_i) state_nxt = ST_HUNT;
         ST_HUNT: if (flag_det_c) state_nxt = ST_FLAG;
         ST_FLAG: begin
            if (brk_rise)         state_nxt = ST_HUNT;
            else if (byte_done_c) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (brk_rise)                    state_nxt = ST_HUNT;
            else if (flag_det_c)             state_nxt = ST_FLAG;
            else if (byte_done_c && over_len) state_nxt = ST_HUNT;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (!rx_en_i) state_nxt = ST_IDLE;
   end

   // Output decode: event strobes to be registered on this clock.
   always_comb begin
      evt_nxt   = '0;
      load_data = 1'b0;
      if (!rx_en_i) begin
         evt_nxt.abort = (state_q == ST_DATA);
      end else if (brk_rise) begin
         evt_nxt.abort = (state_q == ST_DATA);
      end else begin
         case (state_q)
            ST_FLAG: begin
               if (byte_done_c) begin
                  evt_nxt.sof = 1'b1;
                  evt_nxt.dv  = 1'b1;
                  load_data   = 1'b1;
               end
            end
            ST_DATA: begin
               if (flag_det_c) begin
                  evt_nxt.eof = 1'b1;
                  evt_nxt.err = ~tail_ok;
               end else if (byte_done_c) begin
                  if (over_len) begin
                     evt_nxt.abort = 1'b1;
                     evt_nxt.err   = 1'b1;
                  end else begin
                     evt_nxt.dv = 1'b1;
                     load_data  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Registered outputs and frame byte counter.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         data_o       <= 8'h00;
         data_valid_o <= 1'b0;
         sof_o        <= 1'b0;
         eof_o        <= 1'b0;
         err_o        <= 1'b0;
         abort_o      <= 1'b0;
         busy_o       <= 1'b0;
         byte_cnt_q   <= '0;
      end else begin
         data_valid_o <= evt_nxt.dv;
         sof_o        <= evt_nxt.sof;
         eof_o        <= evt_nxt.eof;
         err_o        <= evt_nxt.err;
         abort_o      <= evt_nxt.abort;
         busy_o       <= (state_nxt == ST_DATA);
         if (load_data) data_o <= byte_c;
         if (evt_nxt.sof)     byte_cnt_q <= LEN_W'(1);
         else if (evt_nxt.dv) byte_cnt_q <= byte_cnt_q + LEN_W'(1);
      end
   end

`ifdef IRDA_MIR_RX_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q;
   logic [CNT_W-1:0] abort_cnt_q;

   // Saturating good-frame and aborted/errored-frame counters.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         frame_cnt_q <= '0;
         abort_cnt_q <= '0;
      end else begin
         if (eof_o && !err_o && (frame_cnt_q != '1))
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
         if ((abort_o || (eof_o && err_o)) && (abort_cnt_q != '1))
            abort_cnt_q <= abort_cnt_q + CNT_W'(1);
      end
   end

   assign frame_cnt_o = frame_cnt_q;
   assign abort_cnt_o = abort_cnt_q;
`else
   assign frame_cnt_o = '0;
   assign abort_cnt_o = '0;
`endif

endmodule
